tx_decision_arbiter: RTL and testbench
======================================

TX_DECISION_ARBITER -- requirements
Module: tx_decision_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, meaning number of strategy requesters (2..8).
REQ-002 Parameter BUSY_TIMEOUT, default 16, meaning max cycles to wait for tx_busy rise after tx_dv.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_dv  input  N_REQ  per-requester single-cycle decision-valid strobe.
REQ-006 req_addr  input  8*N_REQ  per-requester instrument address; requester i at bits [8i+7:8i].
REQ-007 req_buysell  input  8*N_REQ  per-requester decision code; 8'hF0 = BUY, 8'h0F = SELL.
REQ-008 req_timestamp  input  32*N_REQ  per-requester timestamp; requester i at bits [32i+31:32i].
REQ-009 tx_busy  input  1  TX framer busy; rises the cycle after an accepted tx_dv and falls after the stop byte.
REQ-010 tx_dv  output  1  single-cycle strobe presenting one decision frame to the TX framer.
REQ-011 tx_addr, tx_buysell, tx_timestamp  output  8/8/32  frame fields; stable from the tx_dv cycle until the next grant.
REQ-012 grant_id  output  3  index of the requester last granted.
REQ-013 pending  output  N_REQ  per-requester slot-occupied flags.
REQ-014 drop_cnt, bad_cnt, timeout_cnt  output  8 each  saturating event counters.

Function
REQ-015 Each requester SHALL own a one-entry slot (addr, buysell, timestamp, pending bit).
REQ-016 A req_dv with buysell of 8'hF0 or 8'h0F SHALL load the slot and set pending on the next edge.
REQ-017 A req_dv with any other buysell SHALL be discarded and SHALL increment bad_cnt.
REQ-018 A valid req_dv to a slot that is already pending and not being granted that cycle SHALL overwrite the slot with the new data and SHALL increment drop_cnt.
REQ-019 A valid req_dv in the same cycle its slot is granted SHALL be stored, leaving pending=1 with the new data; drop_cnt SHALL NOT increment.
REQ-020 The FSM SHALL have states IDLE, SEND, WAIT_HI and WAIT_LO.
REQ-021 IDLE SHALL hold while no pending bit is set or tx_busy=1.
REQ-022 IDLE with any pending and tx_busy=0 SHALL:
- pick the winner round-robin, searching from grant_id+1 upward and wrapping modulo N_REQ;
- register the winner's slot onto tx_* and set grant_id;
- clear the winner's pending bit;
- go to SEND.
REQ-023 SEND SHALL assert tx_dv for exactly one cycle, then go to WAIT_HI.
REQ-024 WAIT_HI SHALL go to WAIT_LO when tx_busy=1.
REQ-025 WAIT_HI SHALL increment timeout_cnt and return to IDLE if tx_busy stays 0 for BUSY_TIMEOUT cycles; the frame is not retried.
REQ-026 WAIT_LO SHALL return to IDLE when tx_busy=0.
REQ-027 Latency: a valid req_dv at cycle t into an idle arbiter with an idle framer SHALL produce tx_dv at cycle t+2.
REQ-028 At most one tx_dv SHALL be issued per tx_busy high period; tx_dv SHALL never be asserted while tx_busy=1.
REQ-029 Every counter SHALL saturate at 8'hFF; simultaneous events on different requesters SHALL each count, with the total still saturating.

Reset
REQ-030 reset SHALL force:
- state IDLE;
- tx_dv=0;
- tx_addr, tx_buysell and tx_timestamp = 0;
- all pending bits = 0;
- all counters = 0;
- grant_id = N_REQ-1, so requester 0 wins first.
REQ-031 reset asserted mid-frame SHALL abandon the frame without further tx_dv; the framer's remaining bytes are not tracked.

Verification
REQ-032 Single request: req_dv[0] with addr 8'h05, buysell 8'hF0, timestamp 32'h12345678 at cycle t; tx_busy rises at t+3 and falls at t+40 -> tx_dv=1 only at t+2, tx_addr=8'h05, tx_timestamp=32'h12345678, grant_id=0.
REQ-033 Round-robin: all four req_dv in the same cycle, framer model responsive -> grants in order 0,1,2,3; a second burst continues 0,1,2,3 after grant 3.
REQ-034 Overwrite: req_dv[2] twice (timestamp 1 then 2) while the framer is busy -> drop_cnt=1; frame sent carries timestamp 2.
REQ-035 Bad code: req_dv[1] with buysell 8'h33 -> no pending, no tx_dv, bad_cnt=1.
REQ-036 Timeout: tx_busy held 0 after tx_dv -> timeout_cnt=1 after 16 cycles; the next pending request is granted afterwards.
REQ-037 Reset during WAIT_LO with two slots pending -> all outputs at reset values the next cycle; no tx_dv until a new req_dv arrives.

Source files
------------

// File: rtl/tx_decision_arbiter.sv
// Round-robin arbiter that collects one pending trading decision per strategy
// requester and hands them one at a time to the TX framer. It waits for the
// framer's busy handshake and gives up on a frame that is never accepted.
module tx_decision_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_dv,
    input  logic [8*N_REQ-1:0]    req_addr,
    input  logic [8*N_REQ-1:0]    req_buysell,
    input  logic [32*N_REQ-1:0]   req_timestamp,
    input  logic                  tx_busy,
    output logic                  tx_dv,
    output logic [7:0]            tx_addr,
    output logic [7:0]            tx_buysell,
    output logic [31:0]           tx_timestamp,
    output logic [2:0]            grant_id,
    output logic [N_REQ-1:0]      pending,
    output logic [7:0]            drop_cnt,
    output logic [7:0]            bad_cnt,
    output logic [7:0]            timeout_cnt
);
    localparam logic [7:0] CODE_BUY  = 8'hF0;
    localparam logic [7:0] CODE_SELL = 8'h0F;
    localparam int         WAIT_W    = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
    state_t state, state_nxt;

    logic [7:0]        slot_addr [N_REQ];
    logic [7:0]        slot_bs   [N_REQ];
    logic [31:0]       slot_ts   [N_REQ];
    logic [N_REQ-1:0]  req_ok, req_bad, req_drop, grant_vec;
    logic              found, grant_fire, timeout_hit;
    logic [2:0]        winner;
    logic [WAIT_W-1:0] wait_cnt;

    function automatic logic [3:0] count_ones(input logic [N_REQ-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < N_REQ; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    // Saturating accumulate: any carry out of the byte pins the result at FF.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {5'b00000, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found  = 1'b0;
        winner = grant_id;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && pending[i] && (i == (int'(grant_id) + k) % N_REQ)) begin
                    found  = 1'b1;
                    winner = 3'(i);
                end
            end
        end
    end

    assign grant_fire = (state == IDLE) && found && !tx_busy;

    // Classify incoming strobes; a slot being granted this cycle is free to refill.
    always_comb begin
        req_ok    = '0;
        req_bad   = '0;
        req_drop  = '0;
        grant_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ok[i]    = req_dv[i] && ((req_buysell[8*i +: 8] == CODE_BUY) ||
                                         (req_buysell[8*i +: 8] == CODE_SELL));
            req_bad[i]   = req_dv[i] && !req_ok[i];
            grant_vec[i] = grant_fire && (winner == 3'(i));
            req_drop[i]  = req_ok[i] && pending[i] && !grant_vec[i];
        end
    end

    // Next-state and strobe decode for the frame handshake.
    always_comb begin
        state_nxt   = state;
        tx_dv       = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE:    if (grant_fire) state_nxt = SEND;
            SEND: begin
                tx_dv     = 1'b1;
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = WAIT_LO;
                end else if (wait_cnt == WAIT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_LO: if (!tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and the busy-rise watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == SEND)
                wait_cnt <= '0;
            else if (state == WAIT_HI && !tx_busy)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Pending flags, grant pointer and event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            grant_id    <= 3'(N_REQ - 1);
            drop_cnt    <= '0;
            bad_cnt     <= '0;
            timeout_cnt <= '0;
        end else begin
            pending     <= (pending & ~grant_vec) | req_ok;
            if (grant_fire) grant_id <= winner;
            drop_cnt    <= sat_add(drop_cnt, count_ones(req_drop));
            bad_cnt     <= sat_add(bad_cnt, count_ones(req_bad));
            timeout_cnt <= sat_add(timeout_cnt, {3'b000, timeout_hit});
        end
    end

    // Per-requester slot storage; newest valid decision always wins.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ok[i]) begin
                slot_addr[i] <= req_addr[8*i +: 8];
                slot_bs[i]   <= req_buysell[8*i +: 8];
                slot_ts[i]   <= req_timestamp[32*i +: 32];
            end
        end
    end

    // Frame fields latch at grant and hold until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_addr      <= '0;
            tx_buysell   <= '0;
            tx_timestamp <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_vec[i]) begin
                    tx_addr      <= slot_addr[i];
                    tx_buysell   <= slot_bs[i];
                    tx_timestamp <= slot_ts[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_tx_decision_arbiter.sv
// Bench for tx_decision_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_tx_decision_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    localparam int PH_FREE = 0, PH_SEND = 1, PH_WAITHI = 2, PH_HIGH = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_dv;
    logic [8*N-1:0]  req_addr, req_buysell;
    logic [32*N-1:0] req_timestamp;
    logic            tx_busy;
    logic            tx_dv;
    logic [7:0]      tx_addr, tx_buysell;
    logic [31:0]     tx_timestamp;
    logic [2:0]      grant_id;
    logic [N-1:0]    pending;
    logic [7:0]      drop_cnt, bad_cnt, timeout_cnt;

    always #5 clk = ~clk;

    tx_decision_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_dv(req_dv), .req_addr(req_addr),
        .req_buysell(req_buysell), .req_timestamp(req_timestamp), .tx_busy(tx_busy),
        .tx_dv(tx_dv), .tx_addr(tx_addr), .tx_buysell(tx_buysell),
        .tx_timestamp(tx_timestamp), .grant_id(grant_id), .pending(pending),
        .drop_cnt(drop_cnt), .bad_cnt(bad_cnt), .timeout_cnt(timeout_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_pend [N];
    logic [7:0]  m_addr [N];
    logic [7:0]  m_bs   [N];
    logic [31:0] m_ts   [N];
    int          m_last, m_drop, m_bad, m_to, m_ph, m_wait;
    logic [7:0]  e_addr, e_bs;
    logic [31:0] e_ts;

    // Framer model
    int fr_mode = 1;
    int fr_len  = 4;
    int fr_cnt  = 0;
    bit dv_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_last = N - 1;
        m_drop = 0; m_bad = 0; m_to = 0;
        m_ph = PH_FREE; m_wait = 0;
        e_addr = '0; e_bs = '0; e_ts = '0;
    endtask

    task automatic model_step(input bit rst_i, input logic [N-1:0] dv_i,
                              input logic [8*N-1:0] a_i, input logic [8*N-1:0] bs_i,
                              input logic [32*N-1:0] ts_i, input bit busy);
        bit   old_pend [N];
        bit   any, grant;
        int   w, j;
        logic [7:0] code;
        if (rst_i) begin
            model_reset();
            return;
        end
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            old_pend[i] = m_pend[i];
            any |= m_pend[i];
        end
        grant = (m_ph == PH_FREE) && any && !busy;
        w = -1;
        if (grant) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (w < 0 && m_pend[j]) w = j;
            end
            e_addr = m_addr[w]; e_bs = m_bs[w]; e_ts = m_ts[w];
            m_last = w;
            m_pend[w] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            code = bs_i[8*i +: 8];
            if (dv_i[i]) begin
                if (code == 8'hF0 || code == 8'h0F) begin
                    if (old_pend[i] && !(grant && w == i)) m_drop++;
                    m_addr[i] = a_i[8*i +: 8];
                    m_bs[i]   = code;
                    m_ts[i]   = ts_i[32*i +: 32];
                    m_pend[i] = 1'b1;
                end else begin
                    m_bad++;
                end
            end
        end
        m_drop = sat(m_drop);
        m_bad  = sat(m_bad);
        case (m_ph)
            PH_FREE:   if (grant) m_ph = PH_SEND;
            PH_SEND:   begin m_ph = PH_WAITHI; m_wait = 0; end
            PH_WAITHI: begin
                if (busy) m_ph = PH_HIGH;
                else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_to = sat(m_to + 1);
                        m_ph = PH_FREE;
                    end
                end
            end
            default:   if (!busy) m_ph = PH_FREE;
        endcase
    endtask

    task automatic compare_outputs();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_pend[i];
        chk("tx_dv",       32'(tx_dv),       32'(m_ph == PH_SEND));
        chk("grant_id",    32'(grant_id),    32'(m_last));
        chk("pending",     32'(pending),     32'(p));
        chk("drop_cnt",    32'(drop_cnt),    32'(m_drop));
        chk("bad_cnt",     32'(bad_cnt),     32'(m_bad));
        chk("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
        chk("tx_addr",     32'(tx_addr),     32'(e_addr));
        chk("tx_buysell",  32'(tx_buysell),  32'(e_bs));
        chk("tx_ts",       tx_timestamp,     e_ts);
    endtask

    // One clock: check, drive inputs and framer busy, advance the model.
    task automatic tick(input bit rst_i, input logic [N-1:0] dv_i,
                        input logic [8*N-1:0] a_i, input logic [8*N-1:0] bs_i,
                        input logic [32*N-1:0] ts_i);
        compare_outputs();
        if (fr_mode == 1 && dv_last) fr_cnt = fr_len;
        reset         = rst_i;
        req_dv        = dv_i;
        req_addr      = a_i;
        req_buysell   = bs_i;
        req_timestamp = ts_i;
        tx_busy       = (fr_cnt > 0);
        chk("dv_while_busy", 32'(tx_dv & tx_busy), 32'd0);
        dv_last = (m_ph == PH_SEND);
        model_step(rst_i, dv_i, a_i, bs_i, ts_i, tx_busy);
        @(posedge clk);
        if (fr_cnt > 0) fr_cnt--;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick(1'b0, '0, '0, '0, '0);
    endtask

    task automatic req_one(input int i, input logic [7:0] a, input logic [7:0] bs,
                           input logic [31:0] ts);
        logic [N-1:0]    dv;
        logic [8*N-1:0]  av, bv;
        logic [32*N-1:0] tv;
        dv = '0; av = '0; bv = '0; tv = '0;
        dv[i] = 1'b1;
        av[8*i +: 8] = a; bv[8*i +: 8] = bs; tv[32*i +: 32] = ts;
        tick(1'b0, dv, av, bv, tv);
    endtask

    task automatic req_all(input logic [7:0] bs, input logic [31:0] ts_base);
        logic [8*N-1:0]  av, bv;
        logic [32*N-1:0] tv;
        for (int i = 0; i < N; i++) begin
            av[8*i +: 8]   = 8'(8'h10 + i);
            bv[8*i +: 8]   = bs;
            tv[32*i +: 32] = ts_base + 32'(i);
        end
        tick(1'b0, '1, av, bv, tv);
    endtask

    task automatic rand_tick(input int rate, input int rst_rate);
        logic [N-1:0]    dv;
        logic [8*N-1:0]  av, bv;
        logic [32*N-1:0] tv;
        int r;
        for (int i = 0; i < N; i++) begin
            dv[i] = ($urandom_range(0, 99) < rate);
            av[8*i +: 8] = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            if (r < 4)      bv[8*i +: 8] = 8'hF0;
            else if (r < 8) bv[8*i +: 8] = 8'h0F;
            else            bv[8*i +: 8] = 8'($urandom_range(0, 255));
            tv[32*i +: 32] = $urandom;
        end
        tick(($urandom_range(0, 999) < rst_rate), dv, av, bv, tv);
    endtask

    initial begin
        reset = 1'b1; req_dv = '0; req_addr = '0; req_buysell = '0;
        req_timestamp = '0; tx_busy = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        tick(1'b1, '0, '0, '0, '0);
        idle(2);

        // Single request with a long framer busy period
        fr_mode = 1; fr_len = 37;
        req_one(0, 8'h05, 8'hF0, 32'h12345678);
        idle(45);

        // Round-robin burst, twice
        fr_len = 3;
        req_all(8'hF0, 32'h100);
        idle(30);
        req_all(8'h0F, 32'h200);
        idle(30);

        // Overwrite while the framer is busy
        fr_len = 20;
        req_one(0, 8'h01, 8'hF0, 32'hA);
        idle(4);
        req_one(2, 8'h22, 8'hF0, 32'd1);
        req_one(2, 8'h22, 8'h0F, 32'd2);
        idle(40);

        // Bad decision code
        req_one(1, 8'h44, 8'h33, 32'h5);
        idle(5);

        // Framer never answers: timeout, then the next pending one goes out
        fr_mode = 0;
        req_all(8'hF0, 32'h300);
        idle(40);
        fr_mode = 1; fr_len = 4;
        idle(60);

        // Reset during the busy-high phase with slots pending
        fr_len = 30;
        req_one(0, 8'h07, 8'hF0, 32'h77);
        idle(5);
        req_one(1, 8'h08, 8'hF0, 32'h88);
        req_one(2, 8'h09, 8'h0F, 32'h99);
        tick(1'b1, '0, '0, '0, '0);
        idle(40);
        req_one(3, 8'h0A, 8'hF0, 32'hAA);
        idle(20);

        // Counter saturation
        fr_len = 200;
        req_one(0, 8'h01, 8'hF0, 32'h1);
        for (int c = 0; c < 80; c++) req_all(8'hF0, 32'(c));
        for (int c = 0; c < 80; c++) req_all(8'h55, 32'(c));
        idle(220);

        // Random traffic with changing framer behaviour
        for (int blk = 0; blk < 60; blk++) begin
            fr_mode = ($urandom_range(0, 4) != 0) ? 1 : 0;
            fr_len  = $urandom_range(1, 12);
            for (int c = 0; c < 50; c++) rand_tick(15, 3);
        end
        fr_mode = 1; fr_len = 2;
        idle(60);
        compare_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
